acquisition_buffer: RTL and testbench
=====================================

ACQUISITION_BUFFER -- requirements
Module: acquisition_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 768, frame length in samples; DEPTH need not be a power of two.
REQ-003 SHALL have parameter PRETRIG, default 384, pre-trigger samples per frame, 1 <= PRETRIG <= DEPTH-1.
REQ-004 SHALL have parameter AUTO_TIMEOUT, default 4096, valid samples spent in ARMED before a forced trigger in auto mode.
REQ-005 SHALL have derived parameter ADDR_W = clog2(DEPTH).
REQ-006 Ports:
- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  din qualifier.
- din  in  DATA_W  unsigned sample.
- level  in  DATA_W  trigger threshold.
- edge_sel  in  1  0 = rising, 1 = falling.
- mode  in  2  00 normal, 01 single, 10 auto, 11 treated as normal.
- arm  in  1  start pulse.
- refresh  in  1  re-arm pulse after a frame.
- r_addr  in  ADDR_W  frame-relative read index.
- dout  out  DATA_W  read data.
- v_max, v_min  out  DATA_W  post-trigger extremes of the last frame.
- frame_ready  out  1  level, frame complete and frozen.
- busy  out  1  high in PRE, ARMED, POST.
- auto_flag  out  1  last frame was force-triggered.

Function
REQ-007 SHALL implement states IDLE, PRE, ARMED, POST, DONE.
REQ-008 SHALL latch mode into an internal register on every accepted arm or refresh; mode changes at any other time have no effect.
REQ-009 IDLE: arm -> PRE, with write pointer, pre-count and post-count cleared.
REQ-010 PRE: SHALL write each valid sample at the write pointer and advance the pointer; after PRETRIG valid samples -> ARMED; triggers are ignored in PRE.
REQ-011 ARMED: SHALL keep writing circularly; a trigger sample -> POST, with trig_addr set to that sample's write address.
REQ-012 POST: SHALL write DEPTH-PRETRIG valid samples, the trigger sample counting as the first; the final write -> DONE.
REQ-013 DONE: no writes. Refresh in normal or auto mode -> PRE. Single mode ignores refresh; arm -> PRE.
REQ-014 Write pointer SHALL wrap from DEPTH-1 to 0.
REQ-015 Rising trigger = prev <= level and cur > level. Falling trigger = prev > level and cur <= level. prev and cur are consecutive valid samples.
REQ-016 prev SHALL update on every valid sample in every state; no trigger is evaluated until one valid sample has been seen after reset.
REQ-017 Auto mode: if AUTO_TIMEOUT valid samples pass in ARMED without a trigger, the next valid sample SHALL be the trigger, and auto_flag is set for that frame; auto_flag clears on entry to PRE.
REQ-018 SHALL track running max/min over POST samples; on entry to POST, max preloads 0 and min preloads all-ones; v_max/v_min SHALL update in the cycle DONE is entered and hold until the next DONE.
REQ-019 frame_ready SHALL be high exactly while in DONE.
REQ-020 Read: dout SHALL equal ram[(trig_addr - PRETRIG + r_addr) mod DEPTH] one clock after r_addr is presented, in any state. r_addr >= DEPTH gives dout = 0.
REQ-021 Frame index PRETRIG SHALL hold the trigger sample.
REQ-022 If arm and refresh assert in the same cycle, arm takes precedence. Arm while busy SHALL be ignored.
REQ-023 Cycles with sample_valid low SHALL not write, count or evaluate a trigger.

Reset
REQ-024 Reset SHALL force IDLE, write pointer 0, counters 0, prev-valid 0, trig_addr 0, v_max 0, v_min 0, frame_ready 0, busy 0, auto_flag 0, dout 0; RAM contents are not cleared.
REQ-025 Reset asserted mid-frame SHALL abandon the frame within one cycle; reset has priority over all inputs.

Verification
(DEPTH=16, PRETRIG=4, AUTO_TIMEOUT=32, DATA_W=12)
REQ-026 Normal rising: arm, ramp 0,1,2,... with level=9 -> trigger on sample 10; reading r_addr 0..15 returns 6..21; v_max=21, v_min=10; frame_ready=1.
REQ-027 Falling edge: edge_sel=1, descending ramp from 20, level=12 -> trigger sample 12; frame index 4 = 12.
REQ-028 Auto: mode=10, constant din=5, level=100 -> frame completes after 4+32+12 valid samples; auto_flag=1; v_max=v_min=5.
REQ-029 Single mode: refresh in DONE -> remains in DONE; arm -> busy=1 next cycle.
REQ-030 Gapped valid plus wrap: sample_valid toggling 50%, trigger late so the pointer wraps -> same frame contents as the ungapped run; a trigger arriving during PRE is not taken.
REQ-031 Reset during POST -> IDLE next cycle, all outputs at reset values; a subsequent arm runs a clean frame.

Source files
------------

// File: rtl/acquisition_buffer.sv
// Triggered acquisition buffer: a circular sample RAM with pre-trigger history,
// edge/auto triggering, post-trigger extremes and frame-relative readback.
module acquisition_buffer #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 768,
  parameter int PRETRIG      = 384,
  parameter int AUTO_TIMEOUT = 4096,
  parameter int ADDR_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] level,
  input  logic              edge_sel,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic              refresh,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] v_max,
  output logic [DATA_W-1:0] v_min,
  output logic              frame_ready,
  output logic              busy,
  output logic              auto_flag
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] M_SINGLE = 2'b01;
  localparam logic [1:0] M_AUTO   = 2'b10;

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
  localparam int IDX_W  = ADDR_W + 2;

  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(DEPTH - PRETRIG - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT);
  localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  DEPTH_X   = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0]  RD_OFS    = IDX_W'(DEPTH - PRETRIG);

  function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] f_min(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [2:0]        r_state;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_wptr;
  logic [CNT_W-1:0]  r_pre_cnt;
  logic [CNT_W-1:0]  r_post_cnt;
  logic [AUTO_W-1:0] r_auto_cnt;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_auto_flag;
  logic [DATA_W-1:0] r_vmax;
  logic [DATA_W-1:0] r_vmin;
  logic [DATA_W-1:0] r_run_max;
  logic [DATA_W-1:0] r_run_min;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_vld;
  logic [DATA_W-1:0] r_dout;

  logic              w_start;
  logic              w_writing;
  logic              w_we;
  logic              w_trig_edge;
  logic              w_force;
  logic              w_take;
  logic [ADDR_W-1:0] w_wptr_nxt;
  logic [DATA_W-1:0] w_max_nxt;
  logic [DATA_W-1:0] w_min_nxt;
  logic [IDX_W-1:0]  w_rd_sum;
  logic [IDX_W-1:0]  w_rd_m1;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_oob;

  // A refresh is only honoured outside single mode; arm is honoured whenever idle or done.
  assign w_start = ((r_state == S_IDLE) && arm) ||
                   ((r_state == S_DONE) && (arm || (refresh && (r_mode != M_SINGLE))));

  assign w_writing  = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_we       = sample_valid && w_writing;
  assign w_wptr_nxt = (r_wptr == WPTR_LAST) ? '0 : r_wptr + 1'b1;

  assign w_trig_edge = sample_valid && r_prev_vld &&
                       (edge_sel ? ((r_prev > level) && (din <= level))
                                 : ((r_prev <= level) && (din > level)));
  assign w_force     = (r_mode == M_AUTO) && (r_auto_cnt == AUTO_LAST);
  assign w_take      = sample_valid && (w_trig_edge || w_force);

  assign w_max_nxt = f_max(r_run_max, din);
  assign w_min_nxt = f_min(r_run_min, din);

  // Frame index 0 sits PRETRIG samples before the trigger; fold modulo DEPTH without a divider.
  assign w_rd_sum = IDX_W'(r_trig_addr) + IDX_W'(r_addr) + RD_OFS;
  assign w_rd_m1  = (w_rd_sum >= DEPTH_X) ? w_rd_sum - DEPTH_X : w_rd_sum;
  assign w_rd_idx = (w_rd_m1 >= DEPTH_X) ? ADDR_W'(w_rd_m1 - DEPTH_X) : ADDR_W'(w_rd_m1);
  assign w_rd_oob = ({2'b00, r_addr} >= DEPTH_X);

  assign dout        = r_dout;
  assign v_max       = r_vmax;
  assign v_min       = r_vmin;
  assign frame_ready = (r_state == S_DONE);
  assign busy        = w_writing;
  assign auto_flag   = r_auto_flag;

  // Capture control: state, pointers, counters, trigger address and frame results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_wptr      <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_auto_cnt  <= '0;
      r_trig_addr <= '0;
      r_auto_flag <= 1'b0;
      r_vmax      <= '0;
      r_vmin      <= '0;
    end else begin
      if (w_we) r_wptr <= w_wptr_nxt;
      if (w_start) begin
        r_state     <= S_PRE;
        r_mode      <= mode;
        r_wptr      <= '0;
        r_pre_cnt   <= '0;
        r_post_cnt  <= '0;
        r_auto_cnt  <= '0;
        r_auto_flag <= 1'b0;
      end else begin
        case (r_state)
          S_PRE: begin
            if (sample_valid) begin
              r_pre_cnt <= r_pre_cnt + 1'b1;
              if (r_pre_cnt == PRE_LAST) begin
                r_state    <= S_ARMED;
                r_auto_cnt <= '0;
              end
            end
          end
          S_ARMED: begin
            if (w_take) begin
              r_trig_addr <= r_wptr;
              r_auto_flag <= !w_trig_edge;
              r_post_cnt  <= CNT_W'(1);
              if (DEPTH - PRETRIG == 1) begin
                r_state <= S_DONE;
                r_vmax  <= din;
                r_vmin  <= din;
              end else begin
                r_state <= S_POST;
              end
            end else if (sample_valid && (r_auto_cnt != AUTO_LAST)) begin
              r_auto_cnt <= r_auto_cnt + 1'b1;
            end
          end
          S_POST: begin
            if (sample_valid) begin
              r_post_cnt <= r_post_cnt + 1'b1;
              if (r_post_cnt == POST_LAST) begin
                r_state <= S_DONE;
                r_vmax  <= w_max_nxt;
                r_vmin  <= w_min_nxt;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Running extremes over post-trigger samples, seeded by the trigger sample itself.
  always_ff @(posedge clk) begin
    if ((r_state == S_ARMED) && w_take) begin
      r_run_max <= din;
      r_run_min <= din;
    end else if ((r_state == S_POST) && sample_valid) begin
      r_run_max <= w_max_nxt;
      r_run_min <= w_min_nxt;
    end
  end

  // Previous-sample tracking for edge detection; runs in every state.
  always_ff @(posedge clk) begin
    if (reset) r_prev_vld <= 1'b0;
    else if (sample_valid) r_prev_vld <= 1'b1;
  end

  // Previous sample value; qualified by r_prev_vld so it needs no reset.
  always_ff @(posedge clk) begin
    if (sample_valid) r_prev <= din;
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we && !reset) r_mem[r_wptr] <= din;
  end

  // Registered frame-relative read port.
  always_ff @(posedge clk) begin
    if (reset) r_dout <= '0;
    else if (w_rd_oob) r_dout <= '0;
    else r_dout <= r_mem[w_rd_idx];
  end

endmodule

// File: tb/tb_acquisition_buffer.sv
// Directed bench for acquisition_buffer with DEPTH=16, PRETRIG=4, AUTO_TIMEOUT=32.
module tb_acquisition_buffer;
  localparam int DW = 12;
  localparam int DP = 16;
  localparam int PT = 4;
  localparam int AT = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic [DW-1:0] din;
  logic [DW-1:0] level;
  logic          edge_sel;
  logic [1:0]    mode;
  logic          arm;
  logic          refresh;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] dout;
  logic [DW-1:0] v_max;
  logic [DW-1:0] v_min;
  logic          frame_ready;
  logic          busy;
  logic          auto_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  rd_vec_t tbl_rise [16];
  rd_vec_t tbl_fall [16];
  rd_vec_t tbl_auto [16];

  acquisition_buffer #(
    .DATA_W(DW), .DEPTH(DP), .PRETRIG(PT), .AUTO_TIMEOUT(AT)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .din(din),
    .level(level), .edge_sel(edge_sel), .mode(mode), .arm(arm),
    .refresh(refresh), .r_addr(r_addr), .dout(dout), .v_max(v_max),
    .v_min(v_min), .frame_ready(frame_ready), .busy(busy), .auto_flag(auto_flag)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int v);
    sample_valid = 1'b1;
    din = DW'(v);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_arm;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_refresh;
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  // Feeds first, first+dir, ... until the frame completes or 100 samples pass.
  task automatic feed(input int first, input int dir, output int n);
    n = 0;
    while (!frame_ready && n < 100) begin
      send(first + dir * n);
      n++;
    end
  endtask

  task automatic check_frame(input int which, input string tag);
    rd_vec_t v;
    for (int i = 0; i < 16; i++) begin
      v = (which == 0) ? tbl_rise[i] : (which == 1) ? tbl_fall[i] : tbl_auto[i];
      r_addr = v.addr;
      tick();
      chk($sformatf("%s_idx%0d", tag, i), dout, v.exp);
    end
  endtask

  initial begin
    int n;
    int q[$];

    // Expected frames: rising ramp gives 6..21, falling ramp gives 16 down to 1.
    for (int i = 0; i < 16; i++) begin
      tbl_rise[i].addr = AW'(i); tbl_rise[i].exp = DW'(i + 6);
      tbl_fall[i].addr = AW'(i); tbl_fall[i].exp = DW'(16 - i);
      tbl_auto[i].addr = AW'(i); tbl_auto[i].exp = DW'(5);
    end

    reset = 1'b1; sample_valid = 1'b0; din = '0; level = DW'(9); edge_sel = 1'b0;
    mode = 2'b00; arm = 1'b0; refresh = 1'b0; r_addr = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", frame_ready, 0);
    chk("rst_auto", auto_flag, 0);
    chk("rst_vmax", v_max, 0);
    chk("rst_vmin", v_min, 0);
    chk("rst_dout", dout, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Normal rising trigger
    pulse_arm();
    chk("rise_busy", busy, 1);
    chk("rise_notready", frame_ready, 0);
    feed(0, 1, n);
    chk("rise_count", n, 22);
    chk("rise_ready", frame_ready, 1);
    chk("rise_busy_done", busy, 0);
    chk("rise_vmax", v_max, 21);
    chk("rise_vmin", v_min, 10);
    chk("rise_auto", auto_flag, 0);
    check_frame(0, "rise");

    // Falling trigger after a normal-mode refresh
    edge_sel = 1'b1; level = DW'(12);
    pulse_refresh();
    chk("fall_busy", busy, 1);
    feed(20, -1, n);
    chk("fall_count", n, 20);
    chk("fall_ready", frame_ready, 1);
    chk("fall_vmax", v_max, 12);
    chk("fall_vmin", v_min, 1);
    check_frame(1, "fall");

    // Auto mode forced trigger on a flat signal
    edge_sel = 1'b0; level = DW'(100); mode = 2'b10;
    pulse_refresh();
    chk("auto_busy", busy, 1);
    feed(5, 0, n);
    chk("auto_count", n, PT + AT + (DP - PT));
    chk("auto_ready", frame_ready, 1);
    chk("auto_flag", auto_flag, 1);
    chk("auto_vmax", v_max, 5);
    chk("auto_vmin", v_min, 5);
    check_frame(2, "auto");

    // Single mode: refresh ignored in DONE, arm restarts
    mode = 2'b01; level = DW'(9);
    pulse_arm();
    chk("single_busy", busy, 1);
    chk("single_autoclr", auto_flag, 0);
    feed(0, 1, n);
    chk("single_count", n, 22);
    chk("single_ready", frame_ready, 1);
    pulse_refresh();
    chk("single_refresh_ready", frame_ready, 1);
    chk("single_refresh_busy", busy, 0);
    pulse_arm();
    chk("single_rearm_busy", busy, 1);

    // Gapped valid, wrap, edge inside PRE ignored, arm while busy ignored
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 2'b00; level = DW'(9); edge_sel = 1'b0;
    chk("gap_reset_busy", busy, 0);
    pulse_arm();
    q = {8, 10, 2, 3, 4, 5, 6, 7, 8, 9, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    for (int v = 10; v <= 21; v++) q.push_back(v);
    n = 0;
    for (int i = 0; i < q.size() && !frame_ready; i++) begin
      send(q[i]);
      n++;
      din = 12'hFFF;
      arm = (i == 10);
      tick();
      arm = 1'b0;
    end
    chk("gap_count", n, 31);
    chk("gap_ready", frame_ready, 1);
    chk("gap_vmax", v_max, 21);
    chk("gap_vmin", v_min, 10);
    check_frame(0, "gap");

    // Reset in the middle of POST, then a clean frame
    pulse_arm();
    for (int v = 0; v <= 12; v++) send(v);
    chk("post_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", frame_ready, 0);
    chk("mid_rst_vmax", v_max, 0);
    chk("mid_rst_vmin", v_min, 0);
    chk("mid_rst_auto", auto_flag, 0);
    chk("mid_rst_dout", dout, 0);
    reset = 1'b0;
    tick();
    chk("mid_rst_idle", busy, 0);
    pulse_arm();
    feed(0, 1, n);
    chk("clean_count", n, 22);
    chk("clean_ready", frame_ready, 1);
    chk("clean_vmax", v_max, 21);
    chk("clean_vmin", v_min, 10);
    check_frame(0, "clean");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
